board_commit_arbiter: RTL

Owns the 3x3 Tic-Tac-Toe board storage and shares it between two users: the pixel renderer, which reads cells every pixel during the active area, and the game logic, which writes moves. Game writes go into a small pending queue. They are applied to the board only during vertical blanking, detected from the vga_sync vsync output, so a move never tears mid-frame. The block sits between the game FSM, vga_sync and the pixel drawer.

---
 rtl/board_commit_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/board_commit_arbiter.sv
// board_commit_arbiter
//   Owns the 3x3 Tic-Tac-Toe board (9 x 2-bit cells) and shares it between the
//   pixel renderer (registered reads every clock) and the game logic (writes).
//   Game writes are queued in a small FIFO and applied only during vertical
//   blanking (falling edge of active-low vsync), so a move never tears mid-frame.
//
//   Optional feature macro: BOARD_ARB_OCCUPIED_CHECK_EN
//     defined   - queued entries aimed at a non-empty cell are discarded at
//                 commit time and flagged on wr_err_o
//     undefined - queued entries overwrite unconditionally
//
// Ports:
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   vsync_i        active-low vsync from vga_sync
//   in_active_i    inActiveArea from vga_sync
//   rd_cell_i      renderer cell index 0..8
//   rd_data_o      registered cell mark (00 empty, 01 X, 10 O)
//   wr_req_i       game write request
//   wr_cell_i      target cell 0..8
//   wr_mark_i      mark to write
//   wr_ready_o     write accepted when wr_req_i && wr_ready_o
//   wr_err_o       1-cycle pulse: accepted write dropped as illegal
//   clear_req_i    1-cycle pulse: wipe board at next commit
//   pending_o      pending-write queue occupancy
//   commit_done_o  1-cycle pulse at end of a commit pass
//   overrun_o      sticky: a commit pass was cut short by active video
module board_commit_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vsync_i,
    input  logic             in_active_i,
    input  logic [3:0]       rd_cell_i,
    output logic [1:0]       rd_data_o,
    input  logic             wr_req_i,
    input  logic [3:0]       wr_cell_i,
    input  logic [1:0]       wr_mark_i,
    output logic             wr_ready_o,
    output logic             wr_err_o,
    input  logic             clear_req_i,
    output logic [CNT_W-1:0] pending_o,
    output logic             commit_done_o,
    output logic             overrun_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned NCELL = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_COMMIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cell_q [NCELL];
    logic [1:0]       cell_d [NCELL];
    logic [5:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clear_pending_q, clear_pending_d;
    logic             overrun_q, overrun_d;
    logic             err_q, err_d;
    logic             vsync_q;
    logic [1:0]       rd_q, rd_val;

    logic             full, accepted, illegal, push, pop, clear_fire, blank_start;
    logic [3:0]       head_cell;
    logic [1:0]       head_mark;
    logic             occ_err;

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_ready_o  = !full && !clear_pending_q;
    assign accepted    = wr_req_i && wr_ready_o;
    assign illegal     = (wr_cell_i >= 4'd9) || (wr_mark_i == 2'b11);
    // A clear only arms once; while armed it has no further effect.
    assign clear_fire  = clear_req_i && !clear_pending_q;
    // A write landing in the same cycle as a clear is flushed with the queue.
    assign push        = accepted && !illegal && !clear_fire;
    assign blank_start = vsync_q && !vsync_i;

    assign head_cell = fifo_mem_q[rptr_q][5:2];
    assign head_mark = fifo_mem_q[rptr_q][1:0];

    // Renderer read mux; out-of-range indices read as empty.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NCELL; i++) begin
            if (rd_cell_i == 4'(i)) rd_val = cell_q[i];
        end
    end

    always_comb begin
        state_d         = state_q;
        cell_d          = cell_q;
        clear_pending_d = clear_pending_q;
        overrun_d       = overrun_q;
        pop             = 1'b0;
        occ_err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (blank_start) begin
                    if (clear_pending_q)    state_d = S_CLEAR;
                    else if (count_q != '0) state_d = S_COMMIT;
                end
            end
            S_CLEAR: begin
                if (in_active_i) begin
                    overrun_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    for (int unsigned i = 0; i < NCELL; i++) cell_d[i] = '0;
                    clear_pending_d = 1'b0;
                    state_d         = (count_q != '0) ? S_COMMIT : S_DONE;
                end
            end
            S_COMMIT: begin
                if (in_active_i) begin
                    overrun_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (count_q == '0) begin
                    // Queue was flushed by a clear mid-pass.
                    state_d = S_DONE;
                end else begin
                    pop = 1'b1;
                    for (int unsigned i = 0; i < NCELL; i++) begin
                        if (head_cell == 4'(i)) begin
`ifdef BOARD_ARB_OCCUPIED_CHECK_EN
                            if (cell_q[i] != 2'b00) occ_err = 1'b1;
                            else                    cell_d[i] = head_mark;
`else
                            cell_d[i] = head_mark;
`endif
                        end
                    end
                    // A simultaneous push keeps the pass going to drain it too.
                    if (count_q == CNT_W'(1) && !push) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_fire) clear_pending_d = 1'b1;
    end

    always_comb begin
        count_d = count_q;
        if (clear_fire) count_d = '0;
        else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign err_d = (accepted && illegal && !clear_fire) || occ_err;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wptr_q] <= {wr_cell_i, wr_mark_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            cell_q          <= '{default: '0};
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            clear_pending_q <= 1'b0;
            overrun_q       <= 1'b0;
            err_q           <= 1'b0;
            vsync_q         <= 1'b1;
            rd_q            <= '0;
        end else begin
            state_q         <= state_d;
            cell_q          <= cell_d;
            count_q         <= count_d;
            clear_pending_q <= clear_pending_d;
            overrun_q       <= overrun_d;
            err_q           <= err_d;
            vsync_q         <= vsync_i;
            rd_q            <= rd_val;
            if (clear_fire) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PTR_W'(1);
                if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

    assign rd_data_o     = rd_q;
    assign wr_err_o      = err_q;
    assign pending_o     = count_q;
    assign commit_done_o = (state_q == S_DONE);
    assign overrun_o     = overrun_q;

endmodule
